// File: rtl/ct_accum_pkg.sv
// rtl/ct_accum_pkg.sv - shared ciphertext types, constants and the slot modadd helper
package ct_accum_pkg;

    localparam int N_SLOTS_L = 8;
    localparam int W_BITS_L  = 13;
    localparam int Q_MOD     = 7710;
    localparam int CNT_W_L   = 8;

    typedef logic [W_BITS_L-1:0] slot_t;
    typedef slot_t [N_SLOTS_L-1:0] vec_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
    } CT_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Both operands must already be < Q; one conditional subtraction suffices.
    function automatic slot_t modadd(input slot_t a, input slot_t b);
        logic [W_BITS_L:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (W_BITS_L+1)'(Q_MOD)) begin
            s = s - (W_BITS_L+1)'(Q_MOD);
        end
        return s[W_BITS_L-1:0];
    endfunction

endpackage

// File: rtl/ct_accum_mod_add_vec.sv
// rtl/ct_accum_mod_add_vec.sv - combinational slot-wise modular add of two vectors
module ct_accum_mod_add_vec
    import ct_accum_pkg::*;
(
    input  vec_t a,
    input  vec_t b,
    output vec_t y
);

    for (genvar gi = 0; gi < N_SLOTS_L; gi++) begin : g_slot
        assign y[gi] = modadd(a[gi], b[gi]);
    end

endmodule

// File: rtl/ct_accum.sv
// rtl/ct_accum.sv - slot-wise mod-q ciphertext accumulator with valid/ready ports
module ct_accum
    import ct_accum_pkg::*;
#(
    parameter int CNT_W = CNT_W_L
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  CT_t              in_ct,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output CT_t              out_ct,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    state_t           state_nxt;
    logic             first;
    CT_t              acc;
    logic [CNT_W-1:0] count;
    vec_t             sum_a;
    vec_t             sum_b;
    logic             take;

    ct_accum_mod_add_vec u_add_a (
        .a (acc.a),
        .b (in_ct.a),
        .y (sum_a)
    );

    ct_accum_mod_add_vec u_add_b (
        .a (acc.b),
        .b (in_ct.b),
        .y (sum_b)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_ACCUM;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    assign take = in_ready && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            first <= 1'b1;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                first <= 1'b0;
                // First term loads directly so no clear cycle is needed between sums.
                if (first) begin
                    acc   <= in_ct;
                    count <= CNT_W'(1);
                end else begin
                    acc.a <= sum_a;
                    acc.b <= sum_b;
                    if (count != {CNT_W{1'b1}}) begin
                        count <= count + CNT_W'(1);
                    end
                end
            end else if (state == ST_HOLD && out_ready) begin
                first <= 1'b1;
            end
        end
    end

    assign out_ct    = acc;
    assign out_count = count;

endmodule

// File: doc/ct_accum.md
# ct_accum

Slot-wise modular accumulator placed directly downstream of the ciphertext × plaintext multiplier. It accepts a stream of ciphertexts (A, B pairs), one per handshake, and sums them slot by slot mod q. When a term is flagged last, it presents the summed ciphertext on a valid/ready output port. This forms the reduction half of ciphertext-by-plaintext inner products and linear layers.

## Interface

Parameters:
- N, N_SLOTS_L: slots per vector.
- W, W_BITS_L: bits per slot.
- Q, Q_MOD: ciphertext modulus, 7710 in the default build.
- CNT_W, 8: width of the term counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_ct and in_last are valid this cycle.
- in_ready  out  1  block can accept a term this cycle.
- in_ct  in  CT_t  term to add. Every slot of A and B is < Q.
- in_last  in  1  this term closes the current sum.
- out_valid  out  1  out_ct and out_count hold a finished sum.
- out_ready  in  1  consumer accepts the sum this cycle.
- out_ct  out  CT_t  accumulated ciphertext, every slot < Q.
- out_count  out  CNT_W  number of terms in the sum, saturating at 2^CNT_W−1.

## Operation

- State machine with two states, ACCUM and HOLD. Reset state is ACCUM, and first=1.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A term is accepted when in_valid=1.
  - If first=1: acc ← in_ct (slot-wise), count ← 1, first ← 0.
  - Otherwise: acc[i] ← modadd(acc[i], in[i]) for every slot of A and B; count ← count+1, saturating.
  - If in_last=1 on the accepted term, the next state is HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_ct=acc and out_count=count, both stable.
  - When out_ready=1, the next state is ACCUM and first ← 1.
  - Accumulator contents are don't-care after this handshake.
- modadd(a,b):
  - Compute s=a+b at W+1 bits.
  - Result is s−Q if s ≥ Q, else s.
  - Exactly one conditional subtraction. Inputs ≥ Q give undefined output.
- When first=1, an accepted term with in_last=1 is a one-term sum, so out_ct equals that input.
- in_valid while in_ready=0 has no effect. The producer holds its term until the handshake.
- count saturates at 2^CNT_W−1. The sum itself keeps accumulating.

## Timing

- Reset values (asynchronous, immediate): state=ACCUM, first=1, in_ready=1, out_valid=0, out_ct=0, out_count=0.
- Input throughput: one term per cycle in ACCUM.
- Latency: out_valid rises in the cycle after the edge that accepts the in_last term.
- Output handshake:
  - out_valid falls in the cycle after the edge where out_valid=1 and out_ready=1.
  - in_ready rises in that same cycle.
  - Result: one bubble cycle per sum between the last term and the next first term.
- in_ready is a function of registered state only and never depends on in_valid.
- Reset mid-sum discards all partial state. The first accepted term after reset starts a new sum.

## Structure

- CT_t, vec_t, N_SLOTS_L, W_BITS_L and Q come from the shared types package/header.
- Add a modadd function beside them in the same shared package so other stages can reuse it.
- Sub-module: one combinational mod_add_vec, instantiated twice (A and B). It performs the N-slot modadd.
- Top level holds the FSM, the accumulator registers and the counter.

## Test plan

All cases use q=7710 and N=8.

- **Single term.** in_ct.A = [1429,1724,3513,5406,5235,6450,2257,74], in_last=1 → next cycle out_valid=1, out_ct.A equals the input, out_count=1.
- **Two terms with wrap.** Term 1: A[0]=1429, B[0]=7531. Term 2: A[0]=7531, B[0]=1429, last. → out_ct.A[0]=1250, B[0]=1250, out_count=2.
- **Boundary sums.**
  - 7709+1 → 0.
  - 7709+7709 → 7708.
  - 0+0 → 0.
  - Three terms of 3855 → 3855 (7710 reduces to 0, then +3855).
- **Backpressure.** out_ready held 0 for 5 cycles → out_valid stays 1, out_ct stays stable, in_ready stays 0. Inputs offered meanwhile are not absorbed (the sum is unchanged). Raising out_ready → one-cycle handshake, then in_ready=1.
- **Back-to-back sums.** Sum 1 = {x, y last}, sum 2 = {z last}. → Sum 2 output equals z alone, with no carry-over from sum 1.
- **Async reset mid-sum.** Assert rst_n=0 between clock edges after 3 accepted terms. → Outputs go to reset values immediately. After release, a single last term 42 gives out_ct slots equal to 42 and out_count=1.
